alu_decoder: RTL and testbench

Registered decode stage that turns a 32-bit RV32I instruction into the operand-select, immediate and 4-bit ALUCtrl code consumed by the execute-stage ALU. It sits between instruction fetch and execute, with valid/ready handshakes on both sides. It holds one decoded instruction in an output register and optionally a second in a skid buffer. Its ALUCtrl encoding is the one the ALU implements.

---
 rtl/alu_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_alu_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decoder.sv
// RV32I decode stage: registered ALUCtrl/operand-select/immediate decode with valid/ready handshakes.
// Build option: define ALU_DECODER_SKID_EN for a one-entry skid buffer and a registered in_ready.
module alu_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_alu_ctrl,
   output logic        out_use_imm,
   output logic        out_src1_pc,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic        out_rd_we,
   output logic        out_illegal,
   output logic [31:0] out_pc
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

   typedef struct packed {
      logic [3:0]  alu_ctrl;
      logic        use_imm;
      logic        src1_pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        illegal;
      logic [31:0] pc;
   } dec_t;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_shamt;
   logic        w_writes_rd;
   logic        w_in_xfer;
   dec_t        w_dec;
   dec_t        r_out;
   logic        r_out_valid;

   assign w_opcode = in_inst[6:0];
   assign w_funct3 = in_inst[14:12];
   assign w_funct7 = in_inst[31:25];
   assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
   assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign w_imm_u  = {in_inst[31:12], 12'b0};
   assign w_shamt  = {27'b0, in_inst[24:20]};

   always_comb begin
      w_dec         = '0;
      w_writes_rd   = 1'b0;
      w_dec.rs1     = in_inst[19:15];
      w_dec.rs2     = in_inst[24:20];
      w_dec.rd      = in_inst[11:7];
      w_dec.pc      = in_pc;
      case (w_opcode)
         OPC_OP: begin
            w_writes_rd    = 1'b1;
            w_dec.alu_ctrl = {w_funct7[5], w_funct3};
            if (!((w_funct7 == 7'b0000000) ||
                  ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))))
               w_dec.illegal = 1'b1;
         end
         OPC_OPIMM: begin
            w_writes_rd    = 1'b1;
            w_dec.use_imm  = 1'b1;
            w_dec.alu_ctrl = {1'b0, w_funct3};
            w_dec.imm      = w_imm_i;
            // Shift-immediates present the bare shift amount, not the funct7-polluted I-immediate.
            if (w_funct3 == 3'b001) begin
               w_dec.imm = w_shamt;
               if (w_funct7 != 7'b0000000)
                  w_dec.illegal = 1'b1;
            end else if (w_funct3 == 3'b101) begin
               w_dec.imm      = w_shamt;
               w_dec.alu_ctrl = in_inst[30] ? 4'b1101 : 4'b0101;
               if ((w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000))
                  w_dec.illegal = 1'b1;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            w_writes_rd   = 1'b1;
            w_dec.use_imm = 1'b1;
            w_dec.imm     = w_imm_i;
         end
         OPC_STORE: begin
            w_dec.use_imm = 1'b1;
            w_dec.imm     = w_imm_s;
         end
         OPC_AUIPC: begin
            w_writes_rd   = 1'b1;
            w_dec.src1_pc = 1'b1;
            w_dec.use_imm = 1'b1;
            w_dec.imm     = w_imm_u;
         end
         OPC_JAL: begin
            // The ALU computes the link address pc+4; the jump target is formed elsewhere.
            w_writes_rd   = 1'b1;
            w_dec.src1_pc = 1'b1;
            w_dec.use_imm = 1'b1;
            w_dec.imm     = 32'd4;
         end
         OPC_LUI: begin
            w_writes_rd    = 1'b1;
            w_dec.use_imm  = 1'b1;
            w_dec.alu_ctrl = 4'b1111;
            w_dec.imm      = w_imm_u;
         end
         OPC_BRANCH: begin
            w_dec.imm = w_imm_b;
            case (w_funct3)
               3'b000, 3'b001: w_dec.alu_ctrl = 4'b1000;
               3'b100, 3'b101: w_dec.alu_ctrl = 4'b0010;
               3'b110, 3'b111: w_dec.alu_ctrl = 4'b0011;
               default:        w_dec.illegal  = 1'b1;
            endcase
         end
         default: w_dec.illegal = 1'b1;
      endcase
      w_dec.rd_we = w_writes_rd & (w_dec.rd != 5'd0) & ~w_dec.illegal;
   end

   assign w_in_xfer = in_valid & in_ready;

`ifdef ALU_DECODER_SKID_EN
   dec_t r_skid;
   logic r_skid_valid;

   assign in_ready = ~r_skid_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out        <= '0;
         r_out_valid  <= 1'b0;
         r_skid       <= '0;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_out_valid || out_ready) begin
         // A held skid entry is always older than anything arriving now.
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_in_xfer) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_in_xfer) begin
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
      end
   end
`else
   assign in_ready = ~r_out_valid | out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_in_xfer) begin
         r_out       <= w_dec;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

   assign out_valid    = r_out_valid;
   assign out_alu_ctrl = r_out.alu_ctrl;
   assign out_use_imm  = r_out.use_imm;
   assign out_src1_pc  = r_out.src1_pc;
   assign out_imm      = r_out.imm;
   assign out_rs1      = r_out.rs1;
   assign out_rs2      = r_out.rs2;
   assign out_rd       = r_out.rd;
   assign out_rd_we    = r_out.rd_we;
   assign out_illegal  = r_out.illegal;
   assign out_pc       = r_out.pc;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed self-checking bench for alu_decoder: decode vectors, back-pressure, flush and async reset.
module tb_alu_decoder;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_alu_ctrl;
   logic        out_use_imm;
   logic        out_src1_pc;
   logic [31:0] out_imm;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic        out_illegal;
   logic [31:0] out_pc;

   int n_checks = 0;
   int n_errors = 0;

   alu_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inst      (in_inst),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_alu_ctrl (out_alu_ctrl),
      .out_use_imm  (out_use_imm),
      .out_src1_pc  (out_src1_pc),
      .out_imm      (out_imm),
      .out_rs1      (out_rs1),
      .out_rs2      (out_rs2),
      .out_rd       (out_rd),
      .out_rd_we    (out_rd_we),
      .out_illegal  (out_illegal),
      .out_pc       (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   // Presents one instruction with out_ready=1; returns one cycle after acceptance.
   task automatic send(input logic [31:0] inst, input logic [31:0] pc);
      logic ok;
      in_inst   = inst;
      in_pc     = pc;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      ok        = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("send_accepted", {31'b0, ok}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [3:0]  alu;
      logic        use_imm;
      logic        src1_pc;
      logic [31:0] imm;
      logic        rd_we;
      logic        illegal;
   } vec_t;

   vec_t vq[$];

   initial begin
      int sent;
      int rcvd;
      logic stalled_prev;
      logic skid_fill_prev;
      logic [31:0] held_pc;
      logic [31:0] held_imm;
      logic in_x;
      logic out_x;

      //             inst          alu   imm? pc?  imm           we    ill
      vq.push_back('{32'h002081B3, 4'h0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}); // add x3,x1,x2
      vq.push_back('{32'h402081B3, 4'h8, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}); // sub
      vq.push_back('{32'h0020B1B3, 4'h3, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}); // sltu
      vq.push_back('{32'h4020C1B3, 4'hC, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1}); // xor with bad funct7
      vq.push_back('{32'h40335293, 4'hD, 1'b1, 1'b0, 32'h00000003, 1'b1, 1'b0}); // srai x5,x6,3
      vq.push_back('{32'h40109093, 4'h1, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b1}); // slli with 0100000
      vq.push_back('{32'hFFF00093, 4'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0}); // addi x1,x0,-1
      vq.push_back('{32'h00000013, 4'h0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0}); // addi x0,x0,0
      vq.push_back('{32'h123450B7, 4'hF, 1'b1, 1'b0, 32'h12345000, 1'b1, 1'b0}); // lui x1,0x12345
      vq.push_back('{32'h00001297, 4'h0, 1'b1, 1'b1, 32'h00001000, 1'b1, 1'b0}); // auipc x5,1
      vq.push_back('{32'h008000EF, 4'h0, 1'b1, 1'b1, 32'h00000004, 1'b1, 1'b0}); // jal x1,+8
      vq.push_back('{32'hFE20AE23, 4'h0, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0}); // sw x2,-4(x1)
      vq.push_back('{32'h00812283, 4'h0, 1'b1, 1'b0, 32'h00000008, 1'b1, 1'b0}); // lw x5,8(x2)
      vq.push_back('{32'h0020E463, 4'h3, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0}); // bltu x1,x2,+8
      vq.push_back('{32'h0000057F, 4'h0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1}); // opcode 0x7F, rd=10

      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_pc     = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("rst_alu_ctrl", {28'b0, out_alu_ctrl}, 32'd0);
      check_eq("rst_imm", out_imm, 32'd0);
      check_eq("rst_pc", out_pc, 32'd0);
      check_eq("rst_rd_we", {31'b0, out_rd_we}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Directed decode vectors, back to back
      for (int i = 0; i < vq.size(); i++) begin
         send(vq[i].inst, 32'h100 + 32'(4 * i));
         check_eq($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
         check_eq($sformatf("v%0d_alu", i), {28'b0, out_alu_ctrl}, {28'b0, vq[i].alu});
         check_eq($sformatf("v%0d_use_imm", i), {31'b0, out_use_imm}, {31'b0, vq[i].use_imm});
         check_eq($sformatf("v%0d_src1_pc", i), {31'b0, out_src1_pc}, {31'b0, vq[i].src1_pc});
         check_eq($sformatf("v%0d_imm", i), out_imm, vq[i].imm);
         check_eq($sformatf("v%0d_rd_we", i), {31'b0, out_rd_we}, {31'b0, vq[i].rd_we});
         check_eq($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vq[i].illegal});
         check_eq($sformatf("v%0d_pc", i), out_pc, 32'h100 + 32'(4 * i));
         if (i == 0) begin
            check_eq("v0_rs1", {27'b0, out_rs1}, 32'd1);
            check_eq("v0_rs2", {27'b0, out_rs2}, 32'd2);
            check_eq("v0_rd", {27'b0, out_rd}, 32'd3);
         end
      end
      @(negedge clk);
      check_eq("drain_valid", {31'b0, out_valid}, 32'd1);
      @(posedge clk);
      #1;

      // Back-pressure: 4 addi xi,x0,i with out_ready low for cycles 1..3
      sent = 0;
      rcvd = 0;
      stalled_prev = 1'b0;
      skid_fill_prev = 1'b0;
      held_pc = '0;
      held_imm = '0;
      for (int c = 0; c < 40 && rcvd < 4; c++) begin
         in_valid  = (sent < 4);
         in_inst   = (32'(sent + 1) << 20) | (32'(sent + 1) << 7) | 32'h13;
         in_pc     = 32'h2000 + 32'(4 * sent);
         out_ready = !(c >= 1 && c <= 3);
         @(negedge clk);
         if (stalled_prev) begin
            check_eq($sformatf("bp_c%0d_hold_valid", c), {31'b0, out_valid}, 32'd1);
            check_eq($sformatf("bp_c%0d_hold_pc", c), out_pc, held_pc);
            check_eq($sformatf("bp_c%0d_hold_imm", c), out_imm, held_imm);
         end
`ifdef ALU_DECODER_SKID_EN
         if (skid_fill_prev)
            check_eq($sformatf("bp_c%0d_in_ready_low", c), {31'b0, in_ready}, 32'd0);
`else
         check_eq($sformatf("bp_c%0d_in_ready", c), {31'b0, in_ready},
                  {31'b0, (!out_valid) | out_ready});
`endif
         in_x  = in_valid & in_ready;
         out_x = out_valid & out_ready;
         if (out_x) begin
            check_eq($sformatf("bp_out%0d_pc", rcvd), out_pc, 32'h2000 + 32'(4 * rcvd));
            check_eq($sformatf("bp_out%0d_imm", rcvd), out_imm, 32'(rcvd + 1));
            rcvd++;
         end
         stalled_prev   = out_valid & ~out_ready;
         skid_fill_prev = in_x & out_valid & ~out_ready;
         held_pc        = out_pc;
         held_imm       = out_imm;
         if (in_x)
            sent++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_eq("bp_received", 32'(rcvd), 32'd4);
      @(negedge clk);
      check_eq("bp_no_dup", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;

      // Flush coincident with an in transfer
      in_inst  = 32'h123450B7;
      in_pc    = 32'h3000;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      check_eq("fl_in_ready_pre", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check_eq("fl_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("fl_in_ready", {31'b0, in_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq($sformatf("fl_never_presented%0d", k), {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Asynchronous reset with an entry held
      in_inst   = 32'h402081B3;
      in_pc     = 32'h4000;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("ar_held_valid", {31'b0, out_valid}, 32'd1);
      check_eq("ar_held_alu", {28'b0, out_alu_ctrl}, 32'd8);
      #2;
      rst = 1'b0;
      #1;
      check_eq("ar_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("ar_alu", {28'b0, out_alu_ctrl}, 32'd0);
      check_eq("ar_pc", out_pc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(32'h123450B7, 32'h5000);
      check_eq("ar_resume_valid", {31'b0, out_valid}, 32'd1);
      check_eq("ar_resume_alu", {28'b0, out_alu_ctrl}, 32'hF);
      check_eq("ar_resume_imm", out_imm, 32'h12345000);
      check_eq("ar_resume_pc", out_pc, 32'h5000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
